// File: rtl/vga_sync_porch.sv
// VGA porch/sync inserter: rebuilds a frame-locked column/row count from the
// active-region syncs and emits blanked video with active-low syncs, 2 clocks late.
module vga_sync_porch #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int FRONT_PORCH_H = 16,
    parameter int BACK_PORCH_H  = 48,
    parameter int FRONT_PORCH_V = 10,
    parameter int BACK_PORCH_V  = 33,
    parameter int VIDEO_WIDTH   = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Locked,
    output logic                   o_Resync_Err
);
    localparam int COL_W = $clog2(TOTAL_COLS);
    localparam int ROW_W = $clog2(TOTAL_ROWS);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
    localparam logic [COL_W-1:0] COL_ACT  = COL_W'(ACTIVE_COLS);
    localparam logic [ROW_W-1:0] ROW_ACT  = ROW_W'(ACTIVE_ROWS);
    localparam logic [COL_W-1:0] HS_FIRST = COL_W'(ACTIVE_COLS + FRONT_PORCH_H);
    localparam logic [COL_W-1:0] HS_LAST  = COL_W'(TOTAL_COLS - BACK_PORCH_H - 1);
    localparam logic [ROW_W-1:0] VS_FIRST = ROW_W'(ACTIVE_ROWS + FRONT_PORCH_V);
    localparam logic [ROW_W-1:0] VS_LAST  = ROW_W'(TOTAL_ROWS - BACK_PORCH_V - 1);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_e;

    lock_state_e            state_q, state_d;
    logic                   vsync_prev_q;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   resync_err_q, resync_err_d;
    logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic [VIDEO_WIDTH-1:0] red_out_q, red_out_d;
    logic [VIDEO_WIDTH-1:0] grn_out_q, grn_out_d;
    logic [VIDEO_WIDTH-1:0] blu_out_q, blu_out_d;

    logic frame_start;
    logic at_frame_end;
    logic in_hsync;
    logic in_vsync;
    logic in_active;
    logic hsync_unused;

    // Horizontal timing comes entirely from the counter; i_HSync is accepted but not needed.
    assign hsync_unused = i_HSync;

    assign frame_start  = i_VSync & ~vsync_prev_q;
    assign at_frame_end = (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_comb begin
        state_d      = state_q;
        resync_err_d = 1'b0;
        col_d        = col_q + 1'b1;
        row_d        = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
        if (frame_start) begin
            col_d        = '0;
            row_d        = '0;
            state_d      = ST_LOCKED;
            resync_err_d = (state_q == ST_LOCKED) && !at_frame_end;
        end
    end

    assign in_hsync  = (col_q >= HS_FIRST) && (col_q <= HS_LAST);
    assign in_vsync  = (row_q >= VS_FIRST) && (row_q <= VS_LAST);
    assign in_active = (col_q < COL_ACT) && (row_q < ROW_ACT);

    // Stage 2 keys off the lock state that travelled with the stage-1 pixel.
    always_comb begin
        hsync_d   = 1'b1;
        vsync_d   = 1'b1;
        red_out_d = '0;
        grn_out_d = '0;
        blu_out_d = '0;
        if (state_q == ST_LOCKED) begin
            hsync_d = ~in_hsync;
            vsync_d = ~in_vsync;
            if (in_active) begin
                red_out_d = red_q;
                grn_out_d = grn_q;
                blu_out_d = blu_q;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_UNLOCKED;
            vsync_prev_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            resync_err_q <= 1'b0;
            red_q        <= '0;
            grn_q        <= '0;
            blu_q        <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            red_out_q    <= '0;
            grn_out_q    <= '0;
            blu_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            vsync_prev_q <= i_VSync;
            col_q        <= col_d;
            row_q        <= row_d;
            resync_err_q <= resync_err_d;
            red_q        <= i_Red_Video;
            grn_q        <= i_Grn_Video;
            blu_q        <= i_Blu_Video;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            red_out_q    <= red_out_d;
            grn_out_q    <= grn_out_d;
            blu_out_q    <= blu_out_d;
        end
    end

    assign o_HSync      = hsync_q;
    assign o_VSync      = vsync_q;
    assign o_Red_Video  = red_out_q;
    assign o_Grn_Video  = grn_out_q;
    assign o_Blu_Video  = blu_out_q;
    assign o_Locked     = (state_q == ST_LOCKED);
    assign o_Resync_Err = resync_err_q;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch: three geometries driven by frame generators and
// checked each cycle against a position-based reference model plus scenario checks.
module tb_vga_sync_porch;
    localparam int NDUT = 3;
    localparam int P_TC  [NDUT] = '{40, 800, 12};
    localparam int P_TR  [NDUT] = '{20, 525, 8};
    localparam int P_AC  [NDUT] = '{24, 640, 8};
    localparam int P_AR  [NDUT] = '{12, 480, 4};
    localparam int P_FPH [NDUT] = '{3, 16, 1};
    localparam int P_BPH [NDUT] = '{5, 48, 1};
    localparam int P_FPV [NDUT] = '{2, 10, 1};
    localparam int P_BPV [NDUT] = '{3, 33, 1};
    localparam logic [15:0] RST_V = 16'hC000;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;
    localparam pix_t RST_PIX = '{hs: 1'b1, vs: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0};

    logic clk = 1'b0;
    logic rst;
    logic [NDUT-1:0] hs_in, vs_in, hs_o, vs_o, lk_o, er_o;
    logic [3:0] r_in [NDUT];
    logic [3:0] g_in [NDUT];
    logic [3:0] b_in [NDUT];
    logic [3:0] r_o  [NDUT];
    logic [3:0] g_o  [NDUT];
    logic [3:0] b_o  [NDUT];

    int checks = 0;
    int errors = 0;

    // generator state
    logic gen_en  [NDUT];
    logic kill_vs [NDUT];
    int   pat     [NDUT];
    int   gcol    [NDUT];
    int   grow    [NDUT];
    int   og_col  [NDUT];
    int   og_row  [NDUT];
    int   vis_col [NDUT];
    int   vis_row [NDUT];

    // reference model state
    logic m_prev_vs [NDUT];
    logic m_locked  [NDUT];
    int   m_pos     [NDUT];
    pix_t pend      [NDUT];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        vga_sync_porch #(
            .TOTAL_COLS    (P_TC[gi]),
            .TOTAL_ROWS    (P_TR[gi]),
            .ACTIVE_COLS   (P_AC[gi]),
            .ACTIVE_ROWS   (P_AR[gi]),
            .FRONT_PORCH_H (P_FPH[gi]),
            .BACK_PORCH_H  (P_BPH[gi]),
            .FRONT_PORCH_V (P_FPV[gi]),
            .BACK_PORCH_V  (P_BPV[gi]),
            .VIDEO_WIDTH   (4)
        ) u_dut (
            .i_Clk        (clk),
            .i_Reset      (rst),
            .i_HSync      (hs_in[gi]),
            .i_VSync      (vs_in[gi]),
            .i_Red_Video  (r_in[gi]),
            .i_Grn_Video  (g_in[gi]),
            .i_Blu_Video  (b_in[gi]),
            .o_HSync      (hs_o[gi]),
            .o_VSync      (vs_o[gi]),
            .o_Red_Video  (r_o[gi]),
            .o_Grn_Video  (g_o[gi]),
            .o_Blu_Video  (b_o[gi]),
            .o_Locked     (lk_o[gi]),
            .o_Resync_Err (er_o[gi])
        );
    end

    function automatic logic [15:0] outv(int d);
        return {hs_o[d], vs_o[d], r_o[d], g_o[d], b_o[d], lk_o[d], er_o[d]};
    endfunction

    task automatic drive(int d);
        int c, r;
        c = gcol[d];
        r = grow[d];
        if (!gen_en[d]) begin
            vs_in[d] = 1'b0;
            hs_in[d] = 1'b0;
            r_in[d]  = 4'h0;
            g_in[d]  = 4'h0;
            b_in[d]  = 4'h0;
        end else begin
            vs_in[d] = (r < P_AR[d]) && !kill_vs[d];
            hs_in[d] = (c < P_AC[d]);
            r_in[d]  = 4'($urandom_range(15));
            g_in[d]  = 4'($urandom_range(15));
            b_in[d]  = 4'($urandom_range(15));
            if (pat[d] == 1) begin
                r_in[d] = 4'hF;
                g_in[d] = 4'hF;
                b_in[d] = 4'hF;
            end else if (pat[d] == 2) begin
                if (c == 0) r_in[d] = 4'h5;
                else if (c == P_AC[d] - 1) r_in[d] = 4'hA;
            end
        end
    endtask

    // Model: each input pixel gets a linear frame position; its output appears
    // 2 clocks later, syncs/blanking derived from (pos % cols, pos / cols).
    task automatic check_model(int d);
        int   frame, c, r;
        logic fs, exp_err;
        logic [15:0] exp_v, act_v;
        pix_t np;
        frame   = P_TC[d] * P_TR[d];
        exp_err = 1'b0;
        if (rst) begin
            m_prev_vs[d] = 1'b0;
            m_locked[d]  = 1'b0;
            m_pos[d]     = 0;
            pend[d]      = RST_PIX;
            exp_v        = RST_V;
        end else begin
            fs = vs_in[d] && !m_prev_vs[d];
            m_prev_vs[d] = vs_in[d];
            if (fs) begin
                exp_err     = m_locked[d] && (((m_pos[d] + 1) % frame) != 0);
                m_pos[d]    = 0;
                m_locked[d] = 1'b1;
            end else begin
                m_pos[d] = (m_pos[d] + 1) % frame;
            end
            exp_v = {pend[d], m_locked[d], exp_err};
            c = m_pos[d] % P_TC[d];
            r = m_pos[d] / P_TC[d];
            np = RST_PIX;
            if (m_locked[d]) begin
                np.hs = !(c >= P_AC[d] + P_FPH[d] && c <= P_TC[d] - P_BPH[d] - 1);
                np.vs = !(r >= P_AR[d] + P_FPV[d] && r <= P_TR[d] - P_BPV[d] - 1);
                if (c < P_AC[d] && r < P_AR[d]) begin
                    np.r = r_in[d];
                    np.g = g_in[d];
                    np.b = b_in[d];
                end
            end
            pend[d] = np;
        end
        act_v = outv(d);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_d%0d t=%0t got=%h exp=%h", d, $time, act_v, exp_v);
        end
    endtask

    task automatic step();
        for (int d = 0; d < NDUT; d++) drive(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_model(d);
            vis_col[d] = og_col[d];
            vis_row[d] = og_row[d];
            og_col[d]  = gcol[d];
            og_row[d]  = grow[d];
            if (gen_en[d]) begin
                gcol[d]++;
                if (gcol[d] == P_TC[d]) begin
                    gcol[d] = 0;
                    grow[d] = (grow[d] + 1) % P_TR[d];
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            gen_en[d] = 1'b0; kill_vs[d] = 1'b0; pat[d] = 0;
            gcol[d] = 0; grow[d] = 0; og_col[d] = -1; og_row[d] = -1;
            vis_col[d] = -1; vis_row[d] = -1;
            m_prev_vs[d] = 1'b0; m_locked[d] = 1'b0; m_pos[d] = 0; pend[d] = RST_PIX;
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (outv(d) !== RST_V) begin
                errors++;
                $display("FAIL reset_state_d%0d got=%h exp=%h", d, outv(d), RST_V);
            end
        end
        step();
        step();
    endtask

    task automatic test_idle();
        int bad [NDUT];
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) bad[d] = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            for (int d = 0; d < NDUT; d++) if (outv(d) !== RST_V) bad[d]++;
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (bad[d] != 0) begin
                errors++;
                $display("FAIL idle_quiet_d%0d got=%0d bad cycles exp=0", d, bad[d]);
            end
        end
    endtask

    task automatic test_lock();
        int hf [NDUT], hr [NDUT], vf [NDUT], vr [NDUT], ec [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            gcol[d] = 0; grow[d] = 0; pat[d] = 1; gen_en[d] = 1'b1;
            hf[d] = -1; hr[d] = -1; vf[d] = -1; vr[d] = -1; ec[d] = 0;
        end
        step();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (lk_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL lock_n1_d%0d got=%b exp=1", d, lk_o[d]);
            end
        end
        for (int j = 1; j < 2400; j++) begin
            step();
            for (int d = 0; d < NDUT; d++) begin
                if (j == 1) begin
                    checks++;
                    if (r_o[d] !== 4'hF) begin
                        errors++;
                        $display("FAIL red_n2_d%0d got=%h exp=f", d, r_o[d]);
                    end
                end
                if (er_o[d]) ec[d]++;
                if (hf[d] < 0 && hs_o[d] == 1'b0) hf[d] = j - 1;
                else if (hf[d] >= 0 && hr[d] < 0 && hs_o[d] == 1'b1) hr[d] = j - 1;
                if (vf[d] < 0 && vs_o[d] == 1'b0) vf[d] = j - 1;
                else if (vf[d] >= 0 && vr[d] < 0 && vs_o[d] == 1'b1) vr[d] = j - 1;
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (hf[d] != P_AC[d] + P_FPH[d]) begin
                errors++;
                $display("FAIL hsync_start_d%0d got=%0d exp=%0d", d, hf[d], P_AC[d] + P_FPH[d]);
            end
            checks++;
            if (hr[d] - hf[d] != P_TC[d] - P_BPH[d] - P_AC[d] - P_FPH[d] || hr[d] < 0) begin
                errors++;
                $display("FAIL hsync_width_d%0d got=%0d exp=%0d", d, hr[d] - hf[d],
                         P_TC[d] - P_BPH[d] - P_AC[d] - P_FPH[d]);
            end
            if (d != 1) begin
                checks++;
                if (vf[d] != (P_AR[d] + P_FPV[d]) * P_TC[d]) begin
                    errors++;
                    $display("FAIL vsync_start_d%0d got=%0d exp=%0d", d, vf[d], (P_AR[d] + P_FPV[d]) * P_TC[d]);
                end
                checks++;
                if (vr[d] - vf[d] != (P_TR[d] - P_BPV[d] - P_AR[d] - P_FPV[d]) * P_TC[d] || vr[d] < 0) begin
                    errors++;
                    $display("FAIL vsync_width_d%0d got=%0d exp=%0d", d, vr[d] - vf[d],
                             (P_TR[d] - P_BPV[d] - P_AR[d] - P_FPV[d]) * P_TC[d]);
                end
            end
            checks++;
            if (ec[d] != 0) begin
                errors++;
                $display("FAIL no_resync_d%0d got=%0d pulses exp=0", d, ec[d]);
            end
        end
    endtask

    task automatic test_align();
        logic [3:0] want;
        logic       hit;
        for (int d = 0; d < NDUT; d++) pat[d] = 2;
        step();
        for (int i = 0; i < 800; i++) begin
            step();
            for (int d = 0; d < NDUT; d++) begin
                hit  = 1'b1;
                want = 4'h0;
                if (vis_row[d] < P_AR[d] && vis_col[d] == 0) want = 4'h5;
                else if (vis_row[d] < P_AR[d] && vis_col[d] == P_AC[d] - 1) want = 4'hA;
                else if (vis_col[d] == P_AC[d]) want = 4'h0;
                else if (vis_row[d] >= P_AR[d] && vis_col[d] == 0) want = 4'h0;
                else hit = 1'b0;
                if (hit) begin
                    checks++;
                    if (r_o[d] !== want) begin
                        errors++;
                        $display("FAIL align_d%0d row=%0d col=%0d got=%h exp=%h",
                                 d, vis_row[d], vis_col[d], r_o[d], want);
                    end
                end
            end
        end
    endtask

    task automatic test_resync();
        int hf [NDUT], ec [NDUT];
        int i;
        for (i = 0; i < 1000 && !(gcol[0] == 10 && grow[0] == 5); i++) step();
        checks++;
        if (!(gcol[0] == 10 && grow[0] == 5)) begin
            errors++;
            $display("FAIL resync_reach got=row%0d/col%0d exp=row5/col10", grow[0], gcol[0]);
        end
        for (int d = 0; d < NDUT; d++) begin
            kill_vs[d] = 1'b1; hf[d] = -1; ec[d] = 0;
        end
        step();
        for (int d = 0; d < NDUT; d++) begin
            kill_vs[d] = 1'b0; gcol[d] = 0; grow[d] = 0;
        end
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (er_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL resync_pulse_d%0d got=%b exp=1", d, er_o[d]);
            end
            if (er_o[d]) ec[d]++;
        end
        for (int j = 1; j < 700; j++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if (er_o[d]) ec[d]++;
                if (hf[d] < 0 && hs_o[d] == 1'b0) hf[d] = j - 1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ec[d] != 1) begin
                errors++;
                $display("FAIL resync_count_d%0d got=%0d exp=1", d, ec[d]);
            end
            checks++;
            if (hf[d] != P_AC[d] + P_FPH[d]) begin
                errors++;
                $display("FAIL resync_hsync_d%0d got=%0d exp=%0d", d, hf[d], P_AC[d] + P_FPH[d]);
            end
        end
    endtask

    task automatic test_async_reset();
        int  early;
        logic found;
        int  i;
        for (i = 0; i < 1000 && !(gcol[0] == 20 && grow[0] == P_AR[0]); i++) step();
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (outv(d) !== RST_V) begin
                errors++;
                $display("FAIL async_reset_d%0d got=%h exp=%h", d, outv(d), RST_V);
            end
        end
        step();
        step();
        rst   = 1'b0;
        early = 0;
        found = 1'b0;
        for (i = 0; i < 1000 && !found; i++) begin
            step();
            if (og_row[0] == 0 && og_col[0] == 0) begin
                found = 1'b1;
                checks++;
                if (lk_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL relock_d0 got=%b exp=1", lk_o[0]);
                end
            end else if (lk_o[0] !== 1'b0) begin
                early++;
            end
        end
        checks++;
        if (early != 0 || !found) begin
            errors++;
            $display("FAIL unlocked_until_fs_d0 got=%0d early/found=%b exp=0/1", early, found);
        end
        for (int k = 0; k < 200; k++) step();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_lock();
        test_align();
        test_resync();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
